imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: writes a program image into instruction memory, the write side of the memory the core fetches from.
- Receives a framed byte stream over a valid/ready interface.
- Assembles little-endian 32-bit words and writes them to instruction memory.
- Holds the core in reset while loading; releases it when the load completes.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; depth = 2**ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned).
- SYNC_BYTE, 8'hA5, start-of-frame byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; transfer when in_valid && in_ready at a rising edge.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address, always word-aligned.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  active-low reset to the core; 0 holds the core.
- busy  out  1  frame in progress.
- done  out  1  sticky; last frame loaded successfully.
- err  out  1  sticky; last frame rejected.

Behaviour:
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (N = 16-bit word count), then N*4 data bytes, least-significant byte of each word first.
- All outputs registered. Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0.
- in_ready=1 from the first cycle after reset deassertion.
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, DONE.
- IDLE: in_ready=1.
  - Accepted byte == SYNC_BYTE -> LEN0; busy=1, cpu_rst=0, done=0, err=0.
  - Any other byte is discarded; no output change.
- LEN0: captures N[7:0] -> LEN1.
- LEN1: captures N[15:8].
  - N==0 -> DONE.
  - N > 2**ADDR_W -> err=1, busy=0, cpu_rst stays 0 -> IDLE.
  - Otherwise word_idx=0, byte_idx=0 -> DATA.
- DATA: accepted byte k (0..3) goes to wdata[8k+7:8k].
  - 4th byte -> WRITE.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr = BASE_ADDR + 4*word_idx, in_ready=0.
  - Then word_idx++. If word_idx == N -> DONE, else -> DATA.
- DONE: one cycle, in_ready=0. Sets done=1, busy=0, cpu_rst=1 -> IDLE.
- Latency: the 4th byte of a word accepted at edge t gives imem_we high during cycle t..t+1. Peak throughput is 4 bytes per 5 cycles.
- in_valid low mid-frame: loader waits indefinitely; no timeout.
- SYNC_BYTE inside length or data fields is treated as plain data.
- imem_we is 0 in every state except WRITE; imem_addr and imem_wdata hold their last values otherwise.
- Address arithmetic is 32-bit; it cannot wrap, because N <= depth is enforced.
- Reset asserted mid-frame: immediate return to reset values. The partial word is discarded, and words already written stay in memory.
- cpu_rst is 0 only between SYNC acceptance and DONE, or after an error, until the next successful frame.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled: state CSUM is inserted before DONE, including the N==0 path.
  - One trailing byte is accepted in CSUM; it must equal the XOR of all data bytes.
  - Match -> DONE.
  - Mismatch -> err=1, busy=0, cpu_rst stays 0 -> IDLE. Already-written words are not rolled back.
- Disabled: no CSUM state; the byte after the last data byte is handled by IDLE.

Test Plan:
- Reset, then stream A5 02 00 13 00 50 00 B3 00 50 00 -> two writes: addr 0x0 data 0x00500013, addr 0x4 data 0x005000B3. done=1, cpu_rst=1, err=0.
- Stream 00 FF A5 01 00 EF BE AD DE -> leading 00 and FF ignored; one write, addr 0x0 data 0xDEADBEEF.
- ADDR_W=8, stream A5 01 01 (N=257) -> err=1, cpu_rst=0, no imem_we; a following valid frame clears err and sets done.
- Valid frame with in_valid toggling every other cycle -> same writes as the back-to-back case. in_ready=0 in each WRITE and DONE cycle; no byte is lost.
- Assert rst after 6 data bytes of a 2-word frame -> first word written, no second write. All outputs at reset values; a new frame loads correctly.
- With IMEM_LOADER_CHECKSUM_EN: A5 01 00 11 22 33 44 44 -> done=1. The same frame with trailer 45 -> err=1, cpu_rst=0, and the word is still written.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the core's instruction memory.
//
// Receives a framed byte stream (SYNC_BYTE, LEN_LO, LEN_HI, N*4 data bytes,
// little-endian words), writes each assembled word to instruction memory and
// keeps the core in reset for the duration of the load.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): a trailing checksum byte,
// the XOR of all data bytes, is expected after the data field (also after an
// empty data field). A mismatch rejects the frame; words already written stay
// in memory.
//
// Stream handshake: a byte transfers on a rising clk edge where
// in_valid && in_ready are both high. in_ready is a registered output that is
// computed from the next FSM state, so it is already low during the WRITE
// and DONE cycles, and the producer may hold in_valid high at any time.
//
// All outputs come straight from flops.

module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Largest accepted word count; a larger N would run past the memory.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_e;

    // State entered once the data field is complete (or empty).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    // FSM state
    state_e      state_q, state_d;

    // Frame bookkeeping
    logic [15:0] len_q, len_d;             // word count N
    logic [15:0] word_idx_q, word_idx_d;   // index of the word being assembled
    logic [1:0]  byte_idx_q, byte_idx_d;   // byte position within the word
    logic [23:0] word_q, word_d;           // lower three bytes of the word

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;           // running XOR of data bytes
`endif

    // Registered outputs
    logic        in_ready_q, in_ready_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Helper terms
    logic        accept;       // a byte transfers at the coming edge
    logic [15:0] len_full;     // N as seen while LEN_HI is on in_data
    logic        len_too_big;  // N exceeds memory depth
    logic        last_word;    // the word being written is the final one

    assign accept      = in_valid && in_ready_q;
    assign len_full    = {in_data, len_q[7:0]};
    assign len_too_big = ({16'd0, len_full} > DEPTH);
    assign last_word   = ((word_idx_q + 16'd1) == len_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: framing decisions
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = S_LEN0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_full == 16'd0) begin
                        state_d = S_TAIL;
                    end else if (len_too_big) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_idx_q == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = last_word ? S_TAIL : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_IDLE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic: next values of every registered output
    always_comb begin
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;

        // Handshake and write strobe follow the state being entered.
        in_ready_d = (state_d != S_WRITE) && (state_d != S_DONE);
        imem_we_d  = (state_d == S_WRITE);

        case (state_q)
            S_IDLE: begin
                // Start of frame: hold the core and clear the sticky flags.
                if (accept && (in_data == SYNC_BYTE)) begin
                    busy_d    = 1'b1;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = 8'd0;
`endif
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    word_idx_d  = 16'd0;
                    byte_idx_d  = 2'd0;
                    // Oversized image: reject, the core stays held in reset.
                    if (len_too_big) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            // Final byte completes the word; present it with
                            // its address during the WRITE cycle.
                            imem_wdata_d = {in_data, word_q};
                            imem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                // Checksum mismatch: reject without rolling back memory.
                if (accept && (in_data != csum_q)) begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
`endif
            default: begin
            end
        endcase

        // Successful completion releases the core.
        if (state_d == S_DONE) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            cpu_rst_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'd0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (default parameters).
// Observed memory writes are collected by a monitor and compared against an
// expected queue filled by the directed steps.

module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_rdy  = 0;
    logic done_prev = 1'b0;

    logic [63:0] exp_q[$];   // {addr, data} expected writes
    logic [63:0] got_q[$];   // {addr, data} observed writes

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: record writes; in_ready must be low in WRITE and DONE cycles.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_q.push_back({imem_addr, imem_wdata});
            if (in_ready !== 1'b0) bad_rdy++;
        end
        if (done === 1'b1 && done_prev === 1'b0 && in_ready !== 1'b0) bad_rdy++;
        done_prev = done;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Driver: offer one byte, wait for it to be accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("send_timeout_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        b = b;
`endif
    endtask

    // Scoreboard: compare observed writes with expected ones, then clear.
    task automatic check_writes(input string tag);
        logic [63:0] g;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 64'bx;
            check({tag, "_write"}, g, exp_q[i]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   {63'd0, in_ready}, 64'd0);
        check({tag, "_imem_we"},    {63'd0, imem_we},  64'd0);
        check({tag, "_imem_addr"},  {32'd0, imem_addr}, 64'd0);
        check({tag, "_imem_wdata"}, {32'd0, imem_wdata}, 64'd0);
        check({tag, "_cpu_rst"},    {63'd0, cpu_rst},  64'd1);
        check({tag, "_busy"},       {63'd0, busy},     64'd0);
        check({tag, "_done"},       {63'd0, done},     64'd0);
        check({tag, "_err"},        {63'd0, err},      64'd0);
    endtask

    initial begin
        logic [7:0] b8;

        // Reset
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(3);
        check_reset_values("reset");
        rst = 1'b1;
        idle(1);
        check("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Two-word frame, back to back
        send_byte(8'hA5);
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_cpu_held", {63'd0, cpu_rst}, 64'd0);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        // 4th byte just accepted: write strobe visible in this cycle
        check("t1_we_latency", {63'd0, imem_we}, 64'd1);
        check("t1_ready_in_write", {63'd0, in_ready}, 64'd0);
        check("t1_addr0", {32'd0, imem_addr}, 64'h0);
        check("t1_data0", {32'd0, imem_wdata}, 64'h0050_0013);
        send_byte(8'hB3); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_csum(8'hA0);
        idle(3);
        exp_q.push_back({32'h0, 32'h0050_0013});
        exp_q.push_back({32'h4, 32'h0050_00B3});
        check_writes("t1");
        check("t1_done", {63'd0, done}, 64'd1);
        check("t1_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("t1_err", {63'd0, err}, 64'd0);
        check("t1_busy_end", {63'd0, busy}, 64'd0);
        check("t1_addr_hold", {32'd0, imem_addr}, 64'h4);

        // Junk bytes before SYNC are discarded
        send_byte(8'h00); send_byte(8'hFF);
        idle(1);
        check("t2_junk_busy", {63'd0, busy}, 64'd0);
        check("t2_junk_done", {63'd0, done}, 64'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_csum(8'h22);
        idle(3);
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        check_writes("t2");
        check("t2_done", {63'd0, done}, 64'd1);

        // Oversized frame N=257 rejected
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        idle(3);
        check_writes("t3_reject");
        check("t3_err", {63'd0, err}, 64'd1);
        check("t3_cpu_held", {63'd0, cpu_rst}, 64'd0);
        check("t3_busy", {63'd0, busy}, 64'd0);
        check("t3_done_clr", {63'd0, done}, 64'd0);
        // A following valid frame clears err
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_csum(8'h08);
        idle(3);
        exp_q.push_back({32'h0, 32'h1234_5678});
        check_writes("t3_recover");
        check("t3_err_clr", {63'd0, err}, 64'd0);
        check("t3_done", {63'd0, done}, 64'd1);
        check("t3_cpu_rst", {63'd0, cpu_rst}, 64'd1);

        // Full-depth frame N=256 is accepted
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            repeat (4) send_byte(b8);
            exp_q.push_back({32'(i * 4), {4{b8}}});
        end
        send_csum(8'h00);
        idle(3);
        check_writes("t4_full");
        check("t4_done", {63'd0, done}, 64'd1);
        check("t4_err", {63'd0, err}, 64'd0);

        // in_valid toggling every other cycle
        send_byte(8'hA5); idle(1);
        send_byte(8'h02); idle(1); send_byte(8'h00); idle(1);
        send_byte(8'h13); idle(1); send_byte(8'h00); idle(1);
        send_byte(8'h50); idle(1); send_byte(8'h00); idle(1);
        send_byte(8'hB3); idle(1); send_byte(8'h00); idle(1);
        send_byte(8'h50); idle(1); send_byte(8'h00); idle(1);
        send_csum(8'hA0);
        idle(3);
        exp_q.push_back({32'h0, 32'h0050_0013});
        exp_q.push_back({32'h4, 32'h0050_00B3});
        check_writes("t5_toggle");
        check("t5_done", {63'd0, done}, 64'd1);

        // Reset after 6 data bytes of a 2-word frame
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rst = 1'b0;
        #1;
        check_reset_values("t6_midreset");
        idle(3);
        exp_q.push_back({32'h0, 32'h4433_2211});
        check_writes("t6_partial");
        rst = 1'b1;
        idle(1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_csum(8'h22);
        idle(3);
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        check_writes("t6_reload");
        check("t6_done", {63'd0, done}, 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        idle(3);
        exp_q.push_back({32'h0, 32'h4433_2211});
        check_writes("t7_csum_ok");
        check("t7_done", {63'd0, done}, 64'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h45);
        idle(3);
        exp_q.push_back({32'h0, 32'h4433_2211});
        check_writes("t7_csum_bad");
        check("t7_err", {63'd0, err}, 64'd1);
        check("t7_cpu_held", {63'd0, cpu_rst}, 64'd0);
        check("t7_done_clr", {63'd0, done}, 64'd0);
`endif

        // Handshake rule across the whole run
        check("ready_low_in_write_done", 64'(bad_rdy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
